mem_ctrl: RTL and testbench

//  Memory-side controller downstream of the CPU control unit. Accepts a
//  one-cycle execute pulse (fetch, READ or WRITE), runs one request/ack

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_mem_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and constants for the memory-side controller.
//   state_t   : controller FSM encoding (IDLE / REQ / DONE)
//   OP_READ / OP_WRITE : values of the I_we / O_ram_we direction bit
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  // Timer width for a given timeout; never narrower than one bit.
  function automatic int timer_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Memory-side controller. Accepts a one-cycle execute pulse from the control
// unit, runs one request/ack transaction on the external RAM bus and returns
// a one-cycle data-ready pulse. Every access is bounded by a timeout so an
// absent RAM cannot hang the CPU; a timed-out read returns all-ones.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   I_execute      start pulse, sampled only while O_mem_ready=1
//   I_we           1=write, 0=read (fetch is a read)
//   I_addr/I_wdata access address / write data, latched with I_execute
//   O_mem_ready    idle, able to accept I_execute
//   O_data_ready   one-cycle completion pulse (reads and writes)
//   O_data         read word, held until the next read completes
//   O_error        one-cycle pulse alongside O_data_ready on timeout
//   O_ram_req/we/addr/wdata  RAM bus request and its latched attributes
//   I_ram_ack/I_ram_rdata    RAM bus completion and read data
//   O_dbg_state    current FSM state, for observation only
//
// Handshake: the control unit may issue I_execute only in a cycle where
// O_mem_ready=1; a pulse seen with O_mem_ready=0 is dropped (no queue).
// On the bus, O_ram_req acts as valid and I_ram_ack as ready: the request and
// its we/addr/wdata stay constant until the edge that samples I_ram_ack=1 (or
// the timeout fires); I_ram_ack is ignored whenever O_ram_req=0.
// ---------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          I_execute,
  input  logic          I_we,
  input  logic [AW-1:0] I_addr,
  input  logic [DW-1:0] I_wdata,
  output logic          O_mem_ready,
  output logic          O_data_ready,
  output logic [DW-1:0] O_data,
  output logic          O_error,
  output logic          O_ram_req,
  output logic          O_ram_we,
  output logic [AW-1:0] O_ram_addr,
  output logic [DW-1:0] O_ram_wdata,
  input  logic          I_ram_ack,
  input  logic [DW-1:0] I_ram_rdata,
  output state_t        O_dbg_state
);

  localparam int            TW       = timer_width(TIMEOUT);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
  localparam logic [DW-1:0] ERR_WORD = '1;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic          mem_ready_q;
  logic          data_ready_q;
  logic [DW-1:0] data_q;
  logic          error_q;
  logic          ram_req_q;
  logic          ram_we_q;
  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      mem_ready_q  <= 1'b0;
      data_ready_q <= 1'b0;
      data_q       <= '0;
      error_q      <= 1'b0;
      ram_req_q    <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mem_ready_q <= 1'b1;
          // mem_ready_q gates acceptance, so the very first idle cycle after
          // reset (ready still 0) cannot start an access.
          if (I_execute && mem_ready_q) begin
            ram_we_q    <= I_we;
            ram_addr_q  <= I_addr;
            ram_wdata_q <= I_wdata;
            ram_req_q   <= 1'b1;
            mem_ready_q <= 1'b0;
            timer_q     <= '0;
            state_q     <= ST_REQ;
          end
        end

        ST_REQ: begin
          // Ack wins over the timeout, including on the final timeout cycle.
          if (I_ram_ack) begin
            ram_req_q    <= 1'b0;
            data_ready_q <= 1'b1;
            if (ram_we_q == OP_READ) begin
              data_q <= I_ram_rdata;
            end
            state_q <= ST_DONE;
          end else if (timer_q == T_LAST) begin
            ram_req_q    <= 1'b0;
            data_ready_q <= 1'b1;
            error_q      <= 1'b1;
            if (ram_we_q == OP_READ) begin
              data_q <= ERR_WORD;
            end
            state_q <= ST_DONE;
          end else begin
            // Only reached below T_LAST, so the timer saturates, never wraps.
            timer_q <= timer_q + TW'(1);
          end
        end

        ST_DONE: begin
          data_ready_q <= 1'b0;
          error_q      <= 1'b0;
          mem_ready_q  <= 1'b1;
          state_q      <= ST_IDLE;
        end

        default: begin
          state_q     <= ST_IDLE;
          ram_req_q   <= 1'b0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign O_mem_ready  = mem_ready_q;
  assign O_data_ready = data_ready_q;
  assign O_data       = data_q;
  assign O_error      = error_q;
  assign O_ram_req    = ram_req_q;
  assign O_ram_we     = ram_we_q;
  assign O_ram_addr   = ram_addr_q;
  assign O_ram_wdata  = ram_wdata_q;
  assign O_dbg_state  = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Directed bench for mem_ctrl (AW=DW=16, TIMEOUT=8). Inputs change 1 ns
// after the rising edge; outputs are read there too. A monitor checks every
// data_ready pulse against an expected queue of {error, data}.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          I_execute = 1'b0;
  logic          I_we = 1'b0;
  logic [AW-1:0] I_addr = '0;
  logic [DW-1:0] I_wdata = '0;
  logic          I_ram_ack = 1'b0;
  logic [DW-1:0] I_ram_rdata = '0;
  logic          O_mem_ready, O_data_ready, O_error;
  logic          O_ram_req, O_ram_we;
  logic [DW-1:0] O_data, O_ram_wdata;
  logic [AW-1:0] O_ram_addr;
  state_t        O_dbg_state;

  mem_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .I_execute    (I_execute),
    .I_we         (I_we),
    .I_addr       (I_addr),
    .I_wdata      (I_wdata),
    .O_mem_ready  (O_mem_ready),
    .O_data_ready (O_data_ready),
    .O_data       (O_data),
    .O_error      (O_error),
    .O_ram_req    (O_ram_req),
    .O_ram_we     (O_ram_we),
    .O_ram_addr   (O_ram_addr),
    .O_ram_wdata  (O_ram_wdata),
    .I_ram_ack    (I_ram_ack),
    .I_ram_rdata  (I_ram_rdata),
    .O_dbg_state  (O_dbg_state)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW:0] exp_q[$];   // {error, data} expected at each data_ready pulse
  int   req_rises = 0;
  logic req_prev  = 1'b0;

  always @(posedge clk) begin
    #2;
    if (O_data_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_dr", {63'd0, O_data_ready}, 64'd0);
      end else begin
        check("sb_err_data", {47'd0, O_error, O_data}, {47'd0, exp_q.pop_front()});
      end
    end
    if (O_ram_req && !req_prev) req_rises++;
    req_prev = O_ram_req;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    I_execute = 1'b1;
    I_we      = we;
    I_addr    = addr;
    I_wdata   = wdata;
    tick();
    I_execute = 1'b0;
  endtask

  // Full access with ack after `delay` extra REQ cycles; bounded wait for ready.
  task automatic do_access(input logic we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                           input int delay, input logic [DW-1:0] exp_data);
    int guard = 0;
    while (!O_mem_ready && guard < 10) begin
      tick();
      guard++;
    end
    check("acc_ready", {63'd0, O_mem_ready}, 64'd1);
    start(we, addr, wdata);
    repeat (delay) tick();
    check("acc_bus", {46'd0, O_ram_req, O_ram_we, O_ram_addr}, {46'd0, 1'b1, we, addr});
    I_ram_ack   = 1'b1;
    I_ram_rdata = rdata;
    exp_q.push_back({1'b0, exp_data});
    tick();
    I_ram_ack = 1'b0;
    check("acc_dr", {63'd0, O_data_ready}, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    int rises0;

    // Reset state
    repeat (3) tick();
    check("rst_outs", {58'd0, O_mem_ready, O_data_ready, O_error, O_ram_req, O_ram_we, 1'b0},
          64'd0);
    check("rst_data", {32'd0, O_data, O_ram_addr}, 64'd0);
    check("rst_state", {62'd0, O_dbg_state}, {62'd0, ST_IDLE});
    reset = 1'b0;
    tick();
    check("rst_ready_after", {63'd0, O_mem_ready}, 64'd1);

    // Read, ack on 2nd REQ cycle, rdata BEEF
    start(OP_READ, 16'h0010, 16'h0000);
    check("rd_req", {46'd0, O_ram_req, O_ram_we, O_ram_addr}, {46'd0, 1'b1, 1'b0, 16'h0010});
    check("rd_busy", {63'd0, O_mem_ready}, 64'd0);
    tick();
    I_ram_ack = 1'b1;
    I_ram_rdata = 16'hBEEF;
    exp_q.push_back({1'b0, 16'hBEEF});
    tick();
    I_ram_ack = 1'b0;
    check("rd_done", {44'd0, O_data_ready, O_error, O_ram_req, O_mem_ready, O_data},
          {44'd0, 4'b1000, 16'hBEEF});
    tick();
    check("rd_after", {62'd0, O_data_ready, O_mem_ready}, {62'd0, 2'b01});

    // Write: bus attributes stable until ack, O_data keeps BEEF
    start(OP_WRITE, 16'h0040, 16'h1234);
    for (int i = 0; i < 3; i++) begin
      check("wr_stable", {30'd0, O_ram_req, O_ram_we, O_ram_addr, O_ram_wdata},
            {30'd0, 1'b1, 1'b1, 16'h0040, 16'h1234});
      tick();
    end
    I_ram_ack = 1'b1;
    I_ram_rdata = 16'hDEAD;
    exp_q.push_back({1'b0, 16'hBEEF});
    tick();
    I_ram_ack = 1'b0;
    check("wr_done", {44'd0, O_data_ready, O_error, O_ram_req, O_mem_ready, O_data},
          {44'd0, 4'b1000, 16'hBEEF});
    tick();

    // Read timeout: req held 8 cycles, then error pulse with FFFF
    start(OP_READ, 16'h0100, 16'h0000);
    cnt = 0;
    while (O_ram_req && cnt < 20) begin
      cnt++;
      if (cnt == 8) exp_q.push_back({1'b1, 16'hFFFF});
      tick();
    end
    check("to_req_cycles", 64'(cnt), 64'd8);
    check("to_done", {44'd0, O_data_ready, O_error, O_ram_req, O_mem_ready, O_data},
          {44'd0, 4'b1100, 16'hFFFF});
    tick();
    check("to_after", {61'd0, O_data_ready, O_error, O_mem_ready}, {61'd0, 3'b001});

    // Stray execute pulses during REQ and DONE, stray ack in IDLE
    rises0 = req_rises;
    start(OP_READ, 16'h0200, 16'h0000);
    start(OP_WRITE, 16'h0300, 16'h9999);
    check("stray_req_addr", {46'd0, O_ram_req, O_ram_we, O_ram_addr},
          {46'd0, 1'b1, 1'b0, 16'h0200});
    I_ram_ack = 1'b1;
    I_ram_rdata = 16'h5A5A;
    exp_q.push_back({1'b0, 16'h5A5A});
    tick();
    I_ram_ack = 1'b0;
    check("stray_dr", {63'd0, O_data_ready}, 64'd1);
    start(OP_READ, 16'h0400, 16'h0000);
    check("stray_done_drop", {62'd0, O_ram_req, O_mem_ready}, {62'd0, 2'b01});
    I_ram_ack = 1'b1;
    I_ram_rdata = 16'h1111;
    tick();
    I_ram_ack = 1'b0;
    check("stray_idle_ack", {46'd0, O_data_ready, O_mem_ready, O_data},
          {46'd0, 2'b01, 16'h5A5A});
    check("stray_one_txn", 64'(req_rises - rises0), 64'd1);

    // Reset in REQ cycle 3 aborts the access
    start(OP_READ, 16'h0500, 16'h0000);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_outs", {61'd0, O_ram_req, O_data_ready, O_mem_ready}, 64'd0);
    reset = 1'b0;
    tick();
    check("abort_ready", {62'd0, O_mem_ready, O_data_ready}, {62'd0, 2'b10});

    // Ack on the final timeout cycle counts as success
    start(OP_READ, 16'h0600, 16'h0000);
    repeat (7) tick();
    check("last_req_held", {63'd0, O_ram_req}, 64'd1);
    I_ram_ack = 1'b1;
    I_ram_rdata = 16'hC0DE;
    exp_q.push_back({1'b0, 16'hC0DE});
    tick();
    I_ram_ack = 1'b0;
    check("last_ack_ok", {46'd0, O_data_ready, O_error, O_data}, {46'd0, 2'b10, 16'hC0DE});

    // Closed loop: fetch, READ, WRITE back-to-back
    do_access(OP_READ,  16'h0000, 16'h0000, 16'h7001, 0, 16'h7001);
    do_access(OP_READ,  16'h0050, 16'h0000, 16'h00AA, 1, 16'h00AA);
    do_access(OP_WRITE, 16'h0060, 16'h0BB0, 16'hFFFF, 2, 16'h00AA);
    tick();
    tick();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
